nf10_drr_input_arbiter: RTL and testbench
=========================================

# nf10_drr_input_arbiter

Five-input, packet-granular AXI4-Stream arbiter using deficit round robin (DRR) weighted by per-port word quanta. Merges the five receive streams (four 10G MACs plus DMA) into the single stream entering the output-port lookup. Replaces plain round-robin arbitration where ports need unequal bandwidth shares. The data path is a zero-latency combinational mux; the scheduler costs one bubble cycle per packet boundary.

## Interface
- C_M_AXIS_DATA_WIDTH, 64, master tdata width (tstrb = width/8)
- C_S_AXIS_DATA_WIDTH, 64, slave tdata width; must equal the master width
- C_M_AXIS_TUSER_WIDTH, 128, master tuser width
- C_S_AXIS_TUSER_WIDTH, 128, slave tuser width; must equal the master width
- QUANTUM_0..QUANTUM_4, 32, credit in words added to a port's deficit on each grant (1..32767)
- DEFICIT_WIDTH, 16, signed deficit counter width
- axi_aclk  in  1  sole clock
- axi_resetn  in  1  asynchronous, active-low reset
- m_axis_tdata/tstrb/tuser/tvalid/tlast  out  per params  merged stream
- m_axis_tready  in  1  downstream ready
- s_axis_tdata_i/tstrb_i/tuser_i/tvalid_i/tlast_i  in  per params  slave stream i, i=0..4
- s_axis_tready_i  out  1  slave ready i
- stats_sel  in  3  port index for statistics readout (present only with NF10_DRR_STATS_EN)
- stats_pkt_cnt  out  32  packets forwarded from port stats_sel (present only with NF10_DRR_STATS_EN)

## Operation
- State: `cur` (3 bits, 0..4), `deficit[0..4]` (signed DEFICIT_WIDTH), FSM {SELECT, XFER}.
- SELECT:
  - Stay on `cur` if tvalid_cur=1 and deficit[cur]>0.
  - Otherwise scan ports cur+1, cur+2, … wrapping, with `cur` checked last. Take the first port j with tvalid_j=1.
  - On a move to j: set cur=j and deficit[j] += QUANTUM_j, saturating at signed max. Go to XFER.
  - On leaving `cur` because tvalid_cur=0: clear deficit[cur] if it is positive. Negative debt is kept.
  - No tvalid anywhere: remain in SELECT; no state change.
- XFER:
  - m_axis_* = s_axis_*_cur.
  - s_axis_tready_cur = m_axis_tready; all other treadys = 0.
  - Each accepted beat (tvalid & tready): deficit[cur] -= 1, saturating at signed min.
  - Accepted beat with tlast=1: go to SELECT.
- A granted packet always completes, even if the deficit goes negative (post-charging). Debt is repaid on later grants.
- tvalid_cur deasserting mid-packet is legal: m_axis_tvalid follows it and the FSM stays in XFER.
- Range checks: stats_sel values 5..7 return 0. Port indices outside 0..4 are never selected.

## Timing
- Reset values:
  - FSM = SELECT; cur = 4, so the first grant scans from port 0.
  - All deficits 0; all packet counters 0.
  - m_axis_tvalid = 0, all s_axis_tready = 0.
- Data path: zero latency, combinational from the selected slave to the master.
- SELECT occupies exactly one cycle whenever any tvalid is high. Minimum gap between the tlast beat and the next packet's first beat is one cycle.
- The grant decision and deficit update are registered at the SELECT→XFER edge. tready is asserted from the first XFER cycle.
- In SELECT: m_axis_tvalid = 0 and all treadys = 0.
- Reset asserted mid-packet: outputs clear immediately (asynchronously). The downstream packet is truncated, and the slave packet resumes mid-stream. Upstream FIFOs must also be reset.

## Configuration
- NF10_DRR_STATS_EN defined:
  - Five 32-bit packet counters, each incremented on its port's accepted tlast beat; they wrap at 2^32.
  - Counters are read combinationally through stats_sel / stats_pkt_cnt.
- NF10_DRR_STATS_EN undefined: the counters and both stats ports are absent. The arbitration behaviour is identical.

## Structure
- Shared package `nf10_drr_pkg`:
  - NUM_PORTS = 5
  - FSM state typedef {SELECT, XFER}
  - Port-index typedef (3 bits)
  - Saturating signed add/sub functions
- Sub-module `nf10_drr_rr_pick`: combinational next-valid-port scanner. Inputs: tvalid[4:0], cur. Outputs: found, index.
- Top level holds the FSM, deficits, mux and stats.

## Test plan
- Single port 0, three 34-word packets, QUANTUM=32, m_axis_tready=1:
  - Deficit sequence 32 → −2, then 30 → −4, then 28 → −6.
  - 102 beats forwarded in 105 cycles.
- All five ports continuously valid, 34-word packets, equal quanta: grant order 0,1,2,3,4,0,… with one bubble cycle between packets.
- QUANTUM_0=128, QUANTUM_1=32, ports 0 and 1 continuously valid, 34-word packets: steady ratio of 4 packets from port 0 to 1 from port 1.
- m_axis_tready toggling every cycle during a 34-word packet:
  - All 34 beats forwarded in order.
  - Deficit decremented only on accepted beats.
  - No slave tready asserted without m_axis_tready.
- axi_resetn pulsed low mid-packet on port 2:
  - Outputs and deficits clear within the same cycle.
  - After release, the first grant goes to the lowest-index valid port.
- With NF10_DRR_STATS_EN, 3 packets from port 1 and 2 from port 4: stats_sel=1 reads 3, stats_sel=4 reads 2, stats_sel=6 reads 0.

Source files
------------

// File: rtl/nf10_drr_pkg.sv
// rtl/nf10_drr_pkg.sv - shared types and saturating deficit arithmetic for the DRR input arbiter
package nf10_drr_pkg;

   localparam int NUM_PORTS = 5;

   typedef enum logic {
      SELECT = 1'b0,
      XFER   = 1'b1
   } state_t;

   typedef logic [2:0] port_idx_t;

   // Adds two values and clamps the result to the range of a w-bit signed counter (w <= 32).
   function automatic logic signed [31:0] sat_add(input logic signed [31:0] a,
                                                  input logic signed [31:0] b,
                                                  input int w);
      logic signed [32:0] sum;
      logic signed [32:0] hi;
      logic signed [32:0] lo;
      logic signed [31:0] res;
      sum = 33'(a) + 33'(b);
      hi  = (33'sd1 <<< (w - 1)) - 33'sd1;
      lo  = -(33'sd1 <<< (w - 1));
      if (sum > hi) begin
         res = hi[31:0];
      end else if (sum < lo) begin
         res = lo[31:0];
      end else begin
         res = sum[31:0];
      end
      return res;
   endfunction

   function automatic logic signed [31:0] sat_sub(input logic signed [31:0] a,
                                                  input logic signed [31:0] b,
                                                  input int w);
      return sat_add(a, -b, w);
   endfunction

endpackage

// File: rtl/nf10_drr_rr_pick.sv
// rtl/nf10_drr_rr_pick.sv - finds the next valid port after cur, wrapping, with cur itself checked last
module nf10_drr_rr_pick
   import nf10_drr_pkg::*;
(
   input  logic [NUM_PORTS-1:0] tvalid,
   input  port_idx_t            cur,
   output logic                 found,
   output port_idx_t            index
);

   port_idx_t  base;
   logic [3:0] cand;

   // Walking from the farthest offset down lets the nearest valid port win.
   always_comb begin
      found = 1'b0;
      index = '0;
      cand  = '0;
      base  = (cur > port_idx_t'(NUM_PORTS - 1)) ? port_idx_t'(NUM_PORTS - 1) : cur;
      for (int k = NUM_PORTS; k >= 1; k--) begin
         cand = {1'b0, base} + 4'(k);
         if (cand >= 4'(NUM_PORTS)) begin
            cand = cand - 4'(NUM_PORTS);
         end
         if (tvalid[cand[2:0]]) begin
            found = 1'b1;
            index = cand[2:0];
         end
      end
   end

endmodule

// File: rtl/nf10_drr_input_arbiter.sv
// rtl/nf10_drr_input_arbiter.sv - five-port packet-granular deficit round robin AXI4-Stream arbiter
// NF10_DRR_STATS_EN adds per-port forwarded-packet counters read through stats_sel/stats_pkt_cnt.
module nf10_drr_input_arbiter
   import nf10_drr_pkg::*;
#(
   parameter int C_M_AXIS_DATA_WIDTH  = 64,
   parameter int C_S_AXIS_DATA_WIDTH  = 64,
   parameter int C_M_AXIS_TUSER_WIDTH = 128,
   parameter int C_S_AXIS_TUSER_WIDTH = 128,
   parameter int QUANTUM_0            = 32,
   parameter int QUANTUM_1            = 32,
   parameter int QUANTUM_2            = 32,
   parameter int QUANTUM_3            = 32,
   parameter int QUANTUM_4            = 32,
   parameter int DEFICIT_WIDTH        = 16
) (
   input  logic                                axi_aclk,
   input  logic                                axi_resetn,

   output logic [C_M_AXIS_DATA_WIDTH-1:0]      m_axis_tdata,
   output logic [C_M_AXIS_DATA_WIDTH/8-1:0]    m_axis_tstrb,
   output logic [C_M_AXIS_TUSER_WIDTH-1:0]     m_axis_tuser,
   output logic                                m_axis_tvalid,
   output logic                                m_axis_tlast,
   input  logic                                m_axis_tready,

   input  logic [C_S_AXIS_DATA_WIDTH-1:0]      s_axis_tdata_0,
   input  logic [C_S_AXIS_DATA_WIDTH/8-1:0]    s_axis_tstrb_0,
   input  logic [C_S_AXIS_TUSER_WIDTH-1:0]     s_axis_tuser_0,
   input  logic                                s_axis_tvalid_0,
   input  logic                                s_axis_tlast_0,
   output logic                                s_axis_tready_0,

   input  logic [C_S_AXIS_DATA_WIDTH-1:0]      s_axis_tdata_1,
   input  logic [C_S_AXIS_DATA_WIDTH/8-1:0]    s_axis_tstrb_1,
   input  logic [C_S_AXIS_TUSER_WIDTH-1:0]     s_axis_tuser_1,
   input  logic                                s_axis_tvalid_1,
   input  logic                                s_axis_tlast_1,
   output logic                                s_axis_tready_1,

   input  logic [C_S_AXIS_DATA_WIDTH-1:0]      s_axis_tdata_2,
   input  logic [C_S_AXIS_DATA_WIDTH/8-1:0]    s_axis_tstrb_2,
   input  logic [C_S_AXIS_TUSER_WIDTH-1:0]     s_axis_tuser_2,
   input  logic                                s_axis_tvalid_2,
   input  logic                                s_axis_tlast_2,
   output logic                                s_axis_tready_2,

   input  logic [C_S_AXIS_DATA_WIDTH-1:0]      s_axis_tdata_3,
   input  logic [C_S_AXIS_DATA_WIDTH/8-1:0]    s_axis_tstrb_3,
   input  logic [C_S_AXIS_TUSER_WIDTH-1:0]     s_axis_tuser_3,
   input  logic                                s_axis_tvalid_3,
   input  logic                                s_axis_tlast_3,
   output logic                                s_axis_tready_3,

   input  logic [C_S_AXIS_DATA_WIDTH-1:0]      s_axis_tdata_4,
   input  logic [C_S_AXIS_DATA_WIDTH/8-1:0]    s_axis_tstrb_4,
   input  logic [C_S_AXIS_TUSER_WIDTH-1:0]     s_axis_tuser_4,
   input  logic                                s_axis_tvalid_4,
   input  logic                                s_axis_tlast_4,
   output logic                                s_axis_tready_4
`ifdef NF10_DRR_STATS_EN
   ,
   input  logic [2:0]                          stats_sel,
   output logic [31:0]                         stats_pkt_cnt
`endif
);

   localparam int QUANTUM_TAB [NUM_PORTS] = '{QUANTUM_0, QUANTUM_1, QUANTUM_2, QUANTUM_3, QUANTUM_4};

   logic [C_S_AXIS_DATA_WIDTH-1:0]   s_tdata [NUM_PORTS];
   logic [C_S_AXIS_DATA_WIDTH/8-1:0] s_tstrb [NUM_PORTS];
   logic [C_S_AXIS_TUSER_WIDTH-1:0]  s_tuser [NUM_PORTS];
   logic [NUM_PORTS-1:0]             s_tvalid;
   logic [NUM_PORTS-1:0]             s_tlast;
   logic [NUM_PORTS-1:0]             s_tready;

   assign s_tdata[0] = s_axis_tdata_0;
   assign s_tdata[1] = s_axis_tdata_1;
   assign s_tdata[2] = s_axis_tdata_2;
   assign s_tdata[3] = s_axis_tdata_3;
   assign s_tdata[4] = s_axis_tdata_4;
   assign s_tstrb[0] = s_axis_tstrb_0;
   assign s_tstrb[1] = s_axis_tstrb_1;
   assign s_tstrb[2] = s_axis_tstrb_2;
   assign s_tstrb[3] = s_axis_tstrb_3;
   assign s_tstrb[4] = s_axis_tstrb_4;
   assign s_tuser[0] = s_axis_tuser_0;
   assign s_tuser[1] = s_axis_tuser_1;
   assign s_tuser[2] = s_axis_tuser_2;
   assign s_tuser[3] = s_axis_tuser_3;
   assign s_tuser[4] = s_axis_tuser_4;
   assign s_tvalid   = {s_axis_tvalid_4, s_axis_tvalid_3, s_axis_tvalid_2, s_axis_tvalid_1, s_axis_tvalid_0};
   assign s_tlast    = {s_axis_tlast_4, s_axis_tlast_3, s_axis_tlast_2, s_axis_tlast_1, s_axis_tlast_0};

   assign s_axis_tready_0 = s_tready[0];
   assign s_axis_tready_1 = s_tready[1];
   assign s_axis_tready_2 = s_tready[2];
   assign s_axis_tready_3 = s_tready[3];
   assign s_axis_tready_4 = s_tready[4];

   state_t                          state;
   state_t                          state_nxt;
   port_idx_t                       cur;
   port_idx_t                       cur_nxt;
   logic signed [DEFICIT_WIDTH-1:0] deficit [NUM_PORTS];
   logic                            grant_load;
   logic                            clear_old;
   logic                            beat;
   logic                            pick_found;
   port_idx_t                       pick_idx;

   nf10_drr_rr_pick u_rr_pick (
      .tvalid (s_tvalid),
      .cur    (cur),
      .found  (pick_found),
      .index  (pick_idx)
   );

   assign beat = (state == XFER) && s_tvalid[cur] && m_axis_tready;

   always_comb begin
      state_nxt  = state;
      cur_nxt    = cur;
      grant_load = 1'b0;
      clear_old  = 1'b0;
      case (state)
         SELECT: begin
            if (s_tvalid[cur] && (deficit[cur] > 0)) begin
               state_nxt = XFER;
            end else if (pick_found) begin
               // Re-granting cur (only valid port, credit spent) still earns a fresh quantum.
               state_nxt  = XFER;
               cur_nxt    = pick_idx;
               grant_load = 1'b1;
               clear_old  = !s_tvalid[cur];
            end
         end
         XFER: begin
            if (beat && s_tlast[cur]) begin
               state_nxt = SELECT;
            end
         end
         default: state_nxt = SELECT;
      endcase
   end

   always_comb begin
      m_axis_tdata  = s_tdata[cur];
      m_axis_tstrb  = s_tstrb[cur];
      m_axis_tuser  = s_tuser[cur];
      m_axis_tvalid = 1'b0;
      m_axis_tlast  = 1'b0;
      s_tready      = '0;
      if (state == XFER) begin
         m_axis_tvalid = s_tvalid[cur];
         m_axis_tlast  = s_tlast[cur];
         s_tready[cur] = m_axis_tready;
      end
   end

   always_ff @(posedge axi_aclk or negedge axi_resetn) begin
      if (!axi_resetn) begin
         state <= SELECT;
         cur   <= port_idx_t'(NUM_PORTS - 1);
      end else begin
         state <= state_nxt;
         cur   <= cur_nxt;
      end
   end

   // Post-charging: a granted packet always finishes, so the deficit may go negative as debt.
   always_ff @(posedge axi_aclk or negedge axi_resetn) begin
      if (!axi_resetn) begin
         for (int i = 0; i < NUM_PORTS; i++) begin
            deficit[i] <= '0;
         end
      end else begin
         for (int i = 0; i < NUM_PORTS; i++) begin
            if (grant_load && (port_idx_t'(i) == cur_nxt)) begin
               deficit[i] <= DEFICIT_WIDTH'(sat_add(32'(deficit[i]), 32'(QUANTUM_TAB[i]), DEFICIT_WIDTH));
            end else if (clear_old && (port_idx_t'(i) == cur) && (deficit[i] > 0)) begin
               deficit[i] <= '0;
            end else if (beat && (port_idx_t'(i) == cur)) begin
               deficit[i] <= DEFICIT_WIDTH'(sat_sub(32'(deficit[i]), 32'sd1, DEFICIT_WIDTH));
            end
         end
      end
   end

`ifdef NF10_DRR_STATS_EN
   logic [31:0] pkt_cnt [NUM_PORTS];

   always_ff @(posedge axi_aclk or negedge axi_resetn) begin
      if (!axi_resetn) begin
         for (int i = 0; i < NUM_PORTS; i++) begin
            pkt_cnt[i] <= '0;
         end
      end else begin
         for (int i = 0; i < NUM_PORTS; i++) begin
            if (beat && s_tlast[cur] && (port_idx_t'(i) == cur)) begin
               pkt_cnt[i] <= pkt_cnt[i] + 32'd1;
            end
         end
      end
   end

   assign stats_pkt_cnt = (stats_sel < 3'(NUM_PORTS)) ? pkt_cnt[stats_sel] : 32'd0;
`endif

endmodule

// File: tb/tb_nf10_drr_input_arbiter.sv
// tb/tb_nf10_drr_input_arbiter.sv - randomized scoreboard bench for the DRR input arbiter
module tb_nf10_drr_input_arbiter;

   localparam int NP = 5;
   localparam int Q [NP] = '{128, 32, 32, 64, 32};

   typedef struct {
      logic [63:0]  data;
      logic [127:0] user;
      logic [7:0]   strb;
      logic         last;
      logic         first;
   } beat_t;

   logic         clk = 1'b0;
   logic         resetn = 1'b0;
   logic [63:0]  m_tdata;
   logic [7:0]   m_tstrb;
   logic [127:0] m_tuser;
   logic         m_tvalid;
   logic         m_tlast;
   logic         m_tready = 1'b1;
   logic [63:0]  s_tdata [NP];
   logic [7:0]   s_tstrb [NP];
   logic [127:0] s_tuser [NP];
   logic [NP-1:0] s_tvalid = '0;
   logic [NP-1:0] s_tlast = '0;
   logic [NP-1:0] s_tready;
`ifdef NF10_DRR_STATS_EN
   logic [2:0]   stats_sel = '0;
   logic [31:0]  stats_pkt_cnt;
`endif

   always #5 clk = ~clk;

   nf10_drr_input_arbiter #(
      .QUANTUM_0(Q[0]), .QUANTUM_1(Q[1]), .QUANTUM_2(Q[2]), .QUANTUM_3(Q[3]), .QUANTUM_4(Q[4])
   ) dut (
      .axi_aclk(clk), .axi_resetn(resetn),
      .m_axis_tdata(m_tdata), .m_axis_tstrb(m_tstrb), .m_axis_tuser(m_tuser),
      .m_axis_tvalid(m_tvalid), .m_axis_tlast(m_tlast), .m_axis_tready(m_tready),
      .s_axis_tdata_0(s_tdata[0]), .s_axis_tstrb_0(s_tstrb[0]), .s_axis_tuser_0(s_tuser[0]),
      .s_axis_tvalid_0(s_tvalid[0]), .s_axis_tlast_0(s_tlast[0]), .s_axis_tready_0(s_tready[0]),
      .s_axis_tdata_1(s_tdata[1]), .s_axis_tstrb_1(s_tstrb[1]), .s_axis_tuser_1(s_tuser[1]),
      .s_axis_tvalid_1(s_tvalid[1]), .s_axis_tlast_1(s_tlast[1]), .s_axis_tready_1(s_tready[1]),
      .s_axis_tdata_2(s_tdata[2]), .s_axis_tstrb_2(s_tstrb[2]), .s_axis_tuser_2(s_tuser[2]),
      .s_axis_tvalid_2(s_tvalid[2]), .s_axis_tlast_2(s_tlast[2]), .s_axis_tready_2(s_tready[2]),
      .s_axis_tdata_3(s_tdata[3]), .s_axis_tstrb_3(s_tstrb[3]), .s_axis_tuser_3(s_tuser[3]),
      .s_axis_tvalid_3(s_tvalid[3]), .s_axis_tlast_3(s_tlast[3]), .s_axis_tready_3(s_tready[3]),
      .s_axis_tdata_4(s_tdata[4]), .s_axis_tstrb_4(s_tstrb[4]), .s_axis_tuser_4(s_tuser[4]),
      .s_axis_tvalid_4(s_tvalid[4]), .s_axis_tlast_4(s_tlast[4]), .s_axis_tready_4(s_tready[4])
`ifdef NF10_DRR_STATS_EN
      ,
      .stats_sel(stats_sel), .stats_pkt_cnt(stats_pkt_cnt)
`endif
   );

   beat_t src_q [NP][$];
   beat_t mdl_q [NP][$];
   int    mdl_len [NP][$];
   beat_t exp_q [$];
   int    m_cur = NP - 1;
   int    m_def [NP] = '{0, 0, 0, 0, 0};
   int    m_stats [NP] = '{0, 0, 0, 0, 0};

   int vectors = 0;
   int miscompares = 0;
   int cyc = 0;
   int t0 = 0;
   int t_last = 0;
   int pkt_serial = 0;
   bit gap_en = 1'b0;
   int rdy_mode = 0;

   task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic add_pkt(input int p, input int len);
      beat_t b;
      for (int i = 0; i < len; i++) begin
         b.data  = {p[3:0], pkt_serial[11:0], i[15:0], 32'($urandom)};
         b.user  = {32'($urandom), 32'($urandom), 32'($urandom), 32'($urandom)};
         b.last  = (i == len - 1);
         b.first = (i == 0);
         b.strb  = b.last ? 8'($urandom_range(1, 255)) : 8'hff;
         src_q[p].push_back(b);
         mdl_q[p].push_back(b);
      end
      mdl_len[p].push_back(len);
      pkt_serial++;
   endtask

   // Reference DRR: whole-packet decisions from queue occupancy and quanta, no cycle detail.
   task automatic run_model();
      int g;
      int len;
      int j;
      bit any;
      forever begin
         any = 1'b0;
         for (int p = 0; p < NP; p++) if (mdl_len[p].size() > 0) any = 1'b1;
         if (!any) break;
         g = -1;
         if (mdl_len[m_cur].size() > 0 && m_def[m_cur] > 0) begin
            g = m_cur;
         end else begin
            for (int k = 1; k <= NP; k++) begin
               j = (m_cur + k) % NP;
               if (g < 0 && mdl_len[j].size() > 0) g = j;
            end
            if (mdl_len[m_cur].size() == 0 && m_def[m_cur] > 0) m_def[m_cur] = 0;
            m_def[g] = m_def[g] + Q[g];
            if (m_def[g] > 32767) m_def[g] = 32767;
            m_cur = g;
         end
         len = mdl_len[g].pop_front();
         m_def[g] = m_def[g] - len;
         if (m_def[g] < -32768) m_def[g] = -32768;
         for (int i = 0; i < len; i++) exp_q.push_back(mdl_q[g].pop_front());
         m_stats[g]++;
      end
   endtask

   function automatic bit src_busy();
      bit b = 1'b0;
      for (int p = 0; p < NP; p++) if (src_q[p].size() > 0) b = 1'b1;
      return b;
   endfunction

   task automatic flush_all();
      for (int p = 0; p < NP; p++) begin
         src_q[p].delete();
         mdl_q[p].delete();
         mdl_len[p].delete();
      end
      exp_q.delete();
   endtask

   task automatic start_phase();
      @(negedge clk);
      #1;
      t0 = cyc;
   endtask

   task automatic finish_phase(input string name, input int expect_cycles);
      int n = 0;
      run_model();
      while ((exp_q.size() > 0 || src_busy()) && n < 20000) begin
         @(posedge clk);
         n++;
      end
      if (exp_q.size() > 0 || src_busy()) begin
         vectors++;
         miscompares++;
         $display("FAIL %s timeout: %0d beats still expected", name, exp_q.size());
         flush_all();
      end else if (expect_cycles > 0) begin
         check({name, "_cycles"}, 128'(t_last - t0), 128'(expect_cycles));
      end
   endtask

   // Source driver: retire accepted head beats, then present the next head (with optional mid-packet gaps).
   initial begin
      bit acc [NP];
      for (int i = 0; i < NP; i++) begin
         s_tdata[i] = '0;
         s_tstrb[i] = '0;
         s_tuser[i] = '0;
      end
      forever begin
         @(negedge clk);
         for (int i = 0; i < NP; i++) acc[i] = s_tvalid[i] & s_tready[i];
         @(posedge clk);
         #1;
         for (int i = 0; i < NP; i++) begin
            if (acc[i] && src_q[i].size() > 0) void'(src_q[i].pop_front());
            if (src_q[i].size() > 0 &&
                !(gap_en && !src_q[i][0].first && $urandom_range(0, 2) == 0)) begin
               s_tvalid[i] = 1'b1;
               s_tdata[i]  = src_q[i][0].data;
               s_tstrb[i]  = src_q[i][0].strb;
               s_tuser[i]  = src_q[i][0].user;
               s_tlast[i]  = src_q[i][0].last;
            end else begin
               s_tvalid[i] = 1'b0;
               s_tdata[i]  = '0;
               s_tstrb[i]  = '0;
               s_tuser[i]  = '0;
               s_tlast[i]  = 1'b0;
            end
         end
         case (rdy_mode)
            1:       m_tready = ~m_tready;
            2:       m_tready = 1'($urandom_range(0, 1));
            default: m_tready = 1'b1;
         endcase
      end
   end

   // Monitor: every accepted master beat is popped from the scoreboard and compared.
   initial begin
      beat_t e;
      forever begin
         @(negedge clk);
         cyc++;
         if (resetn) begin
            check("tready_gated", 128'(s_tready & ~{NP{m_tready}}), 128'(0));
            if (m_tvalid && m_tready) begin
               if (exp_q.size() == 0) begin
                  vectors++;
                  miscompares++;
                  $display("FAIL unexpected_beat: got %0h expected none", m_tdata);
               end else begin
                  e = exp_q.pop_front();
                  check("tdata", 128'(m_tdata), 128'(e.data));
                  check("tuser", m_tuser, e.user);
                  check("tstrb", 128'(m_tstrb), 128'(e.strb));
                  check("tlast", 128'(m_tlast), 128'(e.last));
                  if (exp_q.size() == 0) t_last = cyc;
               end
            end
         end
      end
   end

   initial begin
      // Reset state with a packet already pending on port 0
      start_phase();
      add_pkt(0, 5);
      repeat (2) @(negedge clk);
      check("reset_m_tvalid", 128'(m_tvalid), 128'(0));
      check("reset_s_tready", 128'(s_tready), 128'(0));
      #1 resetn = 1'b1;
      finish_phase("reset_release", 0);

      // Single port, three 34-word packets, quantum 32: one SELECT bubble per packet
      start_phase();
      for (int i = 0; i < 3; i++) add_pkt(1, 34);
      finish_phase("single_port", 105);

      // All five ports backlogged
      start_phase();
      for (int i = 0; i < 3; i++) for (int p = 0; p < NP; p++) add_pkt(p, 34);
      finish_phase("all_ports", 15 * 35);

      // Weighted ports 0 (128) and 1 (32)
      start_phase();
      for (int i = 0; i < 12; i++) add_pkt(0, 34);
      for (int i = 0; i < 4; i++) add_pkt(1, 34);
      finish_phase("weighted", 16 * 35);

      // Downstream ready toggling every cycle
      rdy_mode = 1;
      start_phase();
      add_pkt(3, 34);
      finish_phase("toggle_ready", 0);

      // Random lengths, ports, source gaps and downstream backpressure
      rdy_mode = 2;
      gap_en   = 1'b1;
      for (int r = 0; r < 3; r++) begin
         start_phase();
         for (int i = 0; i < 25; i++) add_pkt($urandom_range(0, NP - 1), $urandom_range(1, 40));
         finish_phase("random", 0);
      end
      rdy_mode = 0;
      gap_en   = 1'b0;

      // Reset in the middle of a port-2 packet
      start_phase();
      add_pkt(2, 34);
      run_model();
      repeat (10) @(posedge clk);
      #3 resetn = 1'b0;
      #1;
      check("midreset_m_tvalid", 128'(m_tvalid), 128'(0));
      check("midreset_s_tready2", 128'(s_tready[2]), 128'(0));
      flush_all();
      m_cur = NP - 1;
      for (int p = 0; p < NP; p++) begin
         m_def[p]   = 0;
         m_stats[p] = 0;
      end
      repeat (2) @(negedge clk);
      #1 resetn = 1'b1;

      // After reset the lowest valid port (1) is granted first
      start_phase();
      for (int i = 0; i < 2; i++) add_pkt(4, $urandom_range(3, 20));
      for (int i = 0; i < 3; i++) add_pkt(1, $urandom_range(3, 20));
      finish_phase("post_reset", 0);

`ifdef NF10_DRR_STATS_EN
      for (int s = 0; s < 8; s++) begin
         @(negedge clk);
         stats_sel = 3'(s);
         #1;
         check("stats_pkt_cnt", 128'(stats_pkt_cnt), 128'((s < NP) ? m_stats[s] : 0));
      end
`endif

      repeat (3) @(negedge clk);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
